// File: rtl/rotor_pkg.sv
// Shared types and constants for the rotor stepper sequencer.
// Holds the FSM state enum, the two-phase-on full-step coil table and the phase step helper.
package rotor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } rotor_state_e;

  // Two-phase-on full-step pattern, indexed by the rotor phase.
  localparam logic [3:0] SEQ [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

  function automatic logic [1:0] phase_step(input logic [1:0] p, input logic fwd);
    return fwd ? p + 2'd1 : p - 2'd1;
  endfunction

endpackage

// File: rtl/rotor_driver_if.sv
// Trigger/direction inputs and coil/status outputs of the rotor sequencer.
// The slave modport is the sequencer; the master modport is whoever drives the trigger.
interface rotor_driver_if #(
  parameter int unsigned STEPS = 8
);
  localparam int unsigned StepW = $clog2(STEPS + 1);

  logic             rotorCheck;
  logic             rotorDir;
  logic [3:0]       coil;
  logic             busy;
  logic             done;
  logic [StepW-1:0] stepCount;
  logic [7:0]       missedTriggers;

  modport master (
    output rotorCheck, rotorDir,
    input  coil, busy, done, stepCount, missedTriggers
  );

  modport slave (
    input  rotorCheck, rotorDir,
    output coil, busy, done, stepCount, missedTriggers
  );

endinterface

// File: rtl/rotor_step_timer.sv
// Step-rate divider: counts 0..CLK_DIV-1 while enabled and flags the terminal count.
// The tick is combinational so the phase advance lands on the same edge the divider wraps.
module rotor_step_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;

  assign tick = enable && (div_q == DivW'(CLK_DIV - 1));

  always_comb begin
    div_d = div_q;
    if (clear || tick) begin
      div_d = '0;
    end else if (enable) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/rotor_driver.sv
// Stepper-rotor sequencer: each rising edge of rotorCheck runs one STEPS-step move,
// holds the coils for HOLD_CYCLES, then de-energizes. One extra trigger is buffered.
module rotor_driver
  import rotor_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned STEPS       = 8,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input logic           clk,
  input logic           reset,
  rotor_driver_if.slave bus
);

  localparam int unsigned StepW = $clog2(STEPS + 1);
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  rotor_state_e     state_q, state_d;
  logic [1:0]       p_q, p_d;
  logic             dir_q, dir_d;
  logic             pending_q, pending_d;
  logic             prev_q, prev_d;
  logic [StepW-1:0] step_q, step_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [7:0]       missed_q, missed_d;
  logic [3:0]       coil_q, coil_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic trig_edge;
  logic start;
  logic tick;

  assign trig_edge = bus.rotorCheck & ~prev_q;
  assign start     = (state_q == StIdle) && (trig_edge || pending_q);

  rotor_step_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .enable(state_q == StRun),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    prev_d    = bus.rotorCheck;
    step_d    = step_q;
    hold_d    = hold_q;
    missed_d  = missed_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          pending_d = 1'b0;
          step_d    = '0;
          dir_d     = bus.rotorDir;
        end
      end
      StRun: begin
        if (tick) begin
          p_d    = phase_step(p_q, dir_q);
          step_d = step_q + 1'b1;
          if (step_q == StepW'(STEPS - 1)) begin
            state_d = StHold;
            hold_d  = '0;
          end
        end
      end
      StHold: begin
        if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Triggers during a move: buffer one, count the rest.
    if ((state_q != StIdle) && trig_edge) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (missed_q != 8'hFF) begin
        missed_d = missed_q + 8'd1;
      end
    end

    busy_d = (state_d != StIdle);
    coil_d = busy_d ? SEQ[p_d] : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      p_q       <= 2'd0;
      dir_q     <= 1'b0;
      pending_q <= 1'b0;
      prev_q    <= 1'b1;
      step_q    <= '0;
      hold_q    <= '0;
      missed_q  <= 8'd0;
      coil_q    <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      prev_q    <= prev_d;
      step_q    <= step_d;
      hold_q    <= hold_d;
      missed_q  <= missed_d;
      coil_q    <= coil_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.coil           = coil_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.stepCount      = step_q;
  assign bus.missedTriggers = missed_q;

endmodule

// File: tb/tb_rotor_driver.sv
// Self-checking bench for rotor_driver: directed vector table, hand-written corner sequences,
// and a per-cycle reference model computing outputs from move start time and elapsed cycles.
module tb_rotor_driver;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned STEPS   = 8;
  localparam int unsigned HOLD    = 3;
  localparam int          MOVE_L  = STEPS * CLK_DIV + HOLD;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rotor_driver_if #(.STEPS(STEPS)) bif ();
  rotor_driver_if #(.STEPS(3))     sif ();

  rotor_driver #(
    .CLK_DIV    (CLK_DIV),
    .STEPS      (STEPS),
    .HOLD_CYCLES(HOLD)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  rotor_driver #(
    .CLK_DIV    (4),
    .STEPS      (3),
    .HOLD_CYCLES(3)
  ) u_small (
    .clk  (clk),
    .reset(reset),
    .bus  (sif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] seq_of(input int i);
    case (i % 4)
      0:       return 4'b1100;
      1:       return 4'b0110;
      2:       return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  // Reference model: a move started at cycle t0 is busy for MOVE_L cycles; k steps are done
  // after (elapsed / CLK_DIV) cycles, capped at STEPS.
  int         m_cyc = 0;
  int         m_t0 = -100000;
  bit         m_started = 1'b0;
  int         m_p0 = 0;
  bit         m_dir = 1'b0;
  bit         m_pend = 1'b0;
  int         m_missed = 0;
  int         m_pbase = 0;
  bit         m_prev = 1'b1;
  logic [3:0] e_coil = '0;
  logic       e_busy = 1'b0;
  logic       e_done = 1'b0;
  int         e_step = 0;
  int         e_missed = 0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin : model
    int  c, n, k;
    bit  edg, busy_c;
    c = m_cyc;
    n = c + 1;
    m_cyc = n;
    if (reset) begin
      m_t0 = -100000;
      m_started = 1'b0;
      m_pend = 1'b0;
      m_missed = 0;
      m_pbase = 0;
      m_prev = 1'b1;
    end else begin
      edg = bif.rotorCheck && !m_prev;
      m_prev = bif.rotorCheck;
      busy_c = m_started && (c > m_t0) && (c <= m_t0 + MOVE_L);
      if (!busy_c && (edg || m_pend)) begin
        m_p0 = m_pbase;
        m_dir = bif.rotorDir;
        m_t0 = c;
        m_started = 1'b1;
        m_pend = 1'b0;
        m_pbase = (m_p0 + (m_dir ? STEPS : 3 * STEPS)) % 4;
      end else if (busy_c && edg) begin
        if (!m_pend) m_pend = 1'b1;
        else if (m_missed < 255) m_missed++;
      end
    end
    e_busy = m_started && (n > m_t0) && (n <= m_t0 + MOVE_L);
    e_done = m_started && (n == m_t0 + MOVE_L + 1);
    e_missed = m_missed;
    if (e_busy) begin
      k = (n - m_t0 - 1) / CLK_DIV;
      if (k > STEPS) k = STEPS;
      e_coil = seq_of(m_p0 + (m_dir ? k : 4 * STEPS - k));
      e_step = k;
    end else begin
      e_coil = 4'b0000;
      e_step = m_started ? STEPS : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_coil", 32'(bif.coil), 32'(e_coil));
      check("model_busy", 32'(bif.busy), 32'(e_busy));
      check("model_done", 32'(bif.done), 32'(e_done));
      check("model_stepCount", 32'(bif.stepCount), e_step);
      check("model_missed", 32'(bif.missedTriggers), e_missed);
    end
  end

  typedef struct {
    bit         start;
    bit         dir;
    int         r;
    logic [3:0] coil;
    bit         busy;
    bit         done;
    int         step;
  } vec_t;

  task automatic do_reset();
    reset = 1'b1;
    bif.rotorCheck = 1'b0;
    sif.rotorCheck = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[$];
    int   cur;
    int   w;
    int   bad;

    bif.rotorCheck = 1'b0;
    bif.rotorDir   = 1'b1;
    sif.rotorCheck = 1'b0;
    sif.rotorDir   = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_coil", 32'(bif.coil), 0);
    check("rst_busy", 32'(bif.busy), 0);
    check("rst_done", 32'(bif.done), 0);
    check("rst_stepCount", 32'(bif.stepCount), 0);
    check("rst_missed", 32'(bif.missedTriggers), 0);

    // Offsets r are cycles after the trigger is sampled; p starts at 0 after reset.
    tbl.push_back('{1, 1, 0,  4'b0000, 0, 0, 0});
    tbl.push_back('{0, 1, 1,  4'b1100, 1, 0, 0});
    tbl.push_back('{0, 1, 4,  4'b1100, 1, 0, 0});
    tbl.push_back('{0, 1, 5,  4'b0110, 1, 0, 1});
    tbl.push_back('{0, 1, 9,  4'b0011, 1, 0, 2});
    tbl.push_back('{0, 1, 32, 4'b1001, 1, 0, 7});
    tbl.push_back('{0, 1, 33, 4'b1100, 1, 0, 8});
    tbl.push_back('{0, 1, 35, 4'b1100, 1, 0, 8});
    tbl.push_back('{0, 1, 36, 4'b0000, 0, 1, 8});
    tbl.push_back('{0, 1, 37, 4'b0000, 0, 0, 8});
    tbl.push_back('{1, 0, 0,  4'b0000, 0, 0, 0});
    tbl.push_back('{0, 0, 1,  4'b1100, 1, 0, 0});
    tbl.push_back('{0, 0, 5,  4'b1001, 1, 0, 1});
    tbl.push_back('{0, 0, 9,  4'b0011, 1, 0, 2});
    tbl.push_back('{0, 0, 13, 4'b0110, 1, 0, 3});
    tbl.push_back('{0, 0, 33, 4'b1100, 1, 0, 8});
    tbl.push_back('{0, 0, 36, 4'b0000, 0, 1, 8});

    cur = 0;
    foreach (tbl[i]) begin
      if (tbl[i].start) begin
        do_reset();
        bif.rotorDir   = tbl[i].dir;
        bif.rotorCheck = 1'b1;
        cur = 0;
      end
      repeat (tbl[i].r - cur) @(negedge clk);
      cur = tbl[i].r;
      check($sformatf("vec%0d_coil", i), 32'(bif.coil), 32'(tbl[i].coil));
      check($sformatf("vec%0d_busy", i), 32'(bif.busy), 32'(tbl[i].busy));
      check($sformatf("vec%0d_done", i), 32'(bif.done), 32'(tbl[i].done));
      check($sformatf("vec%0d_step", i), 32'(bif.stepCount), tbl[i].step);
    end

    // Flag held high across reset release must not trigger; a fresh 0->1 must.
    bif.rotorDir   = 1'b1;
    bif.rotorCheck = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bif.busy !== 1'b0) bad++;
    end
    check("held_high_no_move", bad, 0);
    bif.rotorCheck = 1'b0;
    @(negedge clk);
    bif.rotorCheck = 1'b1;
    @(negedge clk);
    check("rearm_busy", 32'(bif.busy), 1);
    check("rearm_coil", 32'(bif.coil), 32'(4'b1100));

    // Two extra edges during a move: one buffered, one counted as missed.
    do_reset();
    bif.rotorDir   = 1'b1;
    bif.rotorCheck = 1'b1;
    repeat (3) @(negedge clk);
    bif.rotorCheck = 1'b0;
    @(negedge clk);
    bif.rotorCheck = 1'b1;
    @(negedge clk);
    bif.rotorCheck = 1'b0;
    @(negedge clk);
    bif.rotorCheck = 1'b1;
    w = 0;
    while (bif.done !== 1'b1 && w < 80) begin
      @(negedge clk);
      w++;
    end
    check("pend_done_seen", 32'(bif.done), 1);
    check("pend_gap_busy_low", 32'(bif.busy), 0);
    @(negedge clk);
    check("pend_restart_busy", 32'(bif.busy), 1);
    check("pend_restart_done", 32'(bif.done), 0);
    check("pend_restart_coil", 32'(bif.coil), 32'(4'b1100));
    check("pend_restart_step", 32'(bif.stepCount), 0);
    check("pend_missed", 32'(bif.missedTriggers), 1);

    // Reset mid-RUN with a pending trigger: everything clears and nothing follows.
    do_reset();
    bif.rotorCheck = 1'b1;
    repeat (4) @(negedge clk);
    bif.rotorCheck = 1'b0;
    @(negedge clk);
    bif.rotorCheck = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_coil", 32'(bif.coil), 0);
    check("midrst_busy", 32'(bif.busy), 0);
    check("midrst_done", 32'(bif.done), 0);
    check("midrst_step", 32'(bif.stepCount), 0);
    check("midrst_missed", 32'(bif.missedTriggers), 0);
    reset = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (bif.busy !== 1'b0) bad++;
    end
    check("midrst_no_move", bad, 0);

    // STEPS=3 forward ends at p=3, so the next move starts on SEQ[3].
    do_reset();
    sif.rotorDir   = 1'b1;
    sif.rotorCheck = 1'b1;
    @(negedge clk);
    check("s3_first_coil", 32'(sif.coil), 32'(4'b1100));
    check("s3_first_busy", 32'(sif.busy), 1);
    repeat (12) @(negedge clk);
    check("s3_hold_coil", 32'(sif.coil), 32'(4'b1001));
    check("s3_hold_step", 32'(sif.stepCount), 3);
    repeat (3) @(negedge clk);
    check("s3_done", 32'(sif.done), 1);
    check("s3_idle_coil", 32'(sif.coil), 0);
    sif.rotorCheck = 1'b0;
    @(negedge clk);
    sif.rotorCheck = 1'b1;
    @(negedge clk);
    check("s3_second_coil", 32'(sif.coil), 32'(4'b1001));
    check("s3_second_busy", 32'(sif.busy), 1);

    // Edge every other cycle drives the missed counter into saturation.
    do_reset();
    repeat (1200) begin
      @(negedge clk);
      bif.rotorCheck = ~bif.rotorCheck;
    end
    @(negedge clk);
    check("missed_saturates", 32'(bif.missedTriggers), 255);

    // Random triggers, direction and occasional resets against the model.
    do_reset();
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) bif.rotorCheck = ~bif.rotorCheck;
      bif.rotorDir = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rotor_driver.md
# rotor_driver

Stepper-rotor sequencer that sits directly downstream of the data RAM. It consumes the single-bit `rotorCheck` control flag, which software sets by writing memory word 1000. Each rising edge of that flag triggers one fixed-length move of the birdhouse rotor. The block generates the two-phase-on full-step coil pattern, the step timing and a post-move holding period, then de-energizes the coils.

## Interface
Parameters:
- `CLK_DIV`, 4: clock cycles per step. Must be ≥1.
- `STEPS`, 8: full steps per triggered move. Must be ≥1.
- `HOLD_CYCLES`, 3: cycles the coils stay energized after the last step. Must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `rotorCheck`  in  1  trigger level from RAM word 1000; treated as synchronous to `clk`.
- `rotorDir`  in  1  1 = forward (phase index +1), 0 = reverse (−1); sampled at move start.
- `coil`  out  4  coil drive pattern; 0 when idle.
- `busy`  out  1  high while in RUN or HOLD.
- `done`  out  1  one-cycle pulse on the first IDLE cycle after a move.
- `stepCount`  out  $clog2(STEPS+1)  steps completed in the current or last move.
- `missedTriggers`  out  8  saturating count of dropped triggers.

## Operation
- Phase table, indexed by `p` (2 bits): SEQ[0]=4'b1100, SEQ[1]=4'b0110, SEQ[2]=4'b0011, SEQ[3]=4'b1001.
- `p` wraps mod 4 and is retained between moves. It is cleared only by `reset`.
- Edge detect: `edge` = `rotorCheck` & ~`prev`. `prev` resets to 1, so a flag held high across reset release does not trigger.
- States:
  - IDLE: `coil`=0, `busy`=0.
  - RUN: `coil`=SEQ[p]. Divider `div` counts 0..CLK_DIV−1. At `div`==CLK_DIV−1: `p` ← p±1, `stepCount`++, `div` ← 0. After the STEPS-th advance, go to HOLD with hold counter 0.
  - HOLD: `coil`=SEQ[p]. Hold counter counts 0..HOLD_CYCLES−1, then go to IDLE; `done`=1 on that first IDLE cycle.
- Start condition: in IDLE, (`edge` | `pending`). On start:
  - `pending` ← 0
  - `stepCount` ← 0
  - `div` ← 0
  - latch direction from `rotorDir`
- Trigger buffering:
  - `edge` while busy, with `pending`=0: `pending` ← 1.
  - `edge` while busy, with `pending`=1: `missedTriggers`++ (saturates at 255).
- A start can occur on the `done` cycle. In that case `busy` is low for exactly that one cycle.
- `stepCount` holds its final value in IDLE until the next start.
- `rotorDir` changes during a move are ignored.

## Timing
- Edge sampled in IDLE at cycle T: RUN from T+1 with `busy`=1 and `coil`=SEQ[p_start].
- First phase advance is visible at T+1+CLK_DIV. Step k is visible at T+1+k·CLK_DIV.
- HOLD is entered at H = T+1+STEPS·CLK_DIV.
- IDLE at H+HOLD_CYCLES: `coil`=0, `busy`=0, `done`=1.
- Total move length: STEPS·CLK_DIV + HOLD_CYCLES cycles.
- With CLK_DIV=1, the phase advances every RUN cycle.
- Reset values, applied the cycle after `reset` is sampled high, even mid-move:
  - state IDLE
  - `coil`=0, `busy`=0, `done`=0
  - `stepCount`=0, `missedTriggers`=0
  - `p`=0, `pending`=0, `prev`=1

## Structure
- Package `rotor_pkg`: the state enum (IDLE, RUN, HOLD) and the SEQ phase-constant array.
- Sub-module `rotor_step_timer`: the CLK_DIV divider. Inputs: clear, enable. Output: a one-cycle `tick` at terminal count.
- Edge detect, FSM, pending flag and counters live in `rotor_driver`.

## Test plan
- Defaults, `rotorDir`=1, `rotorCheck` 0→1 sampled at cycle 10:
  - `busy`=1, `coil`=1100 at 11.
  - `coil`=0110 at 15.
  - HOLD at 43.
  - `coil`=0, `busy`=0, `done`=1, `stepCount`=8 at 46.
  - `p`=0 after the move.
- `rotorDir`=0: `coil` sequence 1100→1001→0011→0110, one change per 4 cycles.
- Two extra edges during a move:
  - one pending move starts the cycle after `done`;
  - `missedTriggers`=1;
  - `busy` is low for exactly one cycle between moves.
- `rotorCheck` held high across reset release → no move. Then 0 then 1 → move starts.
- `reset` asserted mid-RUN with `pending`=1 → next cycle all outputs at reset values, and no move follows.
- STEPS=3, `rotorDir`=1: first move ends with `p`=3; the second move starts with `coil`=1001.
